// File: rtl/data_mem_ctrl_if.sv
// CPU-side bus of the data memory: request fields toward the memory,
// handshake status and load data back to the CPU.
interface data_mem_ctrl_if;
  logic        Req;
  logic        WrEn;
  logic [31:0] Adr;
  logic [31:0] DataIn;
  logic [1:0]  Size;
  logic        Unsigned;
  logic        Ready;
  logic        Done;
  logic        Err;
  logic [31:0] DataOut;

  modport master (
    output Req, WrEn, Adr, DataIn, Size, Unsigned,
    input  Ready, Done, Err, DataOut
  );

  modport slave (
    input  Req, WrEn, Adr, DataIn, Size, Unsigned,
    output Ready, Done, Err, DataOut
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// Data memory for the CPU datapath: byte/half/word loads and stores with
// sign/zero extension, request/done handshake with configurable wait states,
// alignment checking and an optional zero sweep of the array after reset.
module data_mem_ctrl #(
  parameter int ADDR_W         = 12,
  parameter int WAIT_CYC       = 2,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic           Clk,
  input  logic           Reset,
  data_mem_ctrl_if.slave bus
);

  localparam int IDX_W = ADDR_W - 2;
  localparam int DEPTH = 1 << IDX_W;
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;
  localparam logic [IDX_W-1:0] LAST_IDX = '1;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_WAIT,
    ST_DONE
  } state_t;

  // Control state and registered outputs
  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]  clr_ptr_q, clr_ptr_d;
  logic              ready_q, ready_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [31:0]       dout_q, dout_d;

  // Captured request fields
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [31:0]       din_q, din_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;

  // Storage array
  logic [31:0]       mem_q [DEPTH];

  // Fields of the access being committed
  logic              acc_wr;
  logic [ADDR_W-1:0] acc_adr;
  logic [31:0]       acc_din;
  logic [1:0]        acc_size;
  logic              acc_uns;
  logic [IDX_W-1:0]  acc_idx;
  logic [31:0]       cur_word;
  logic              accept;
  logic              finish;
  logic              illegal;

  logic              mem_we;
  logic [IDX_W-1:0]  mem_widx;
  logic [31:0]       mem_wdata;

  // Address bits above ADDR_W alias onto the array and are deliberately dropped
  logic              unused_adr_hi;
  assign unused_adr_hi = ^bus.Adr[31:ADDR_W];

  // Size 11, odd halfword and unaligned word accesses are rejected
  function automatic logic is_illegal(input logic [1:0] size, input logic [1:0] lane);
    logic bad;
    case (size)
      2'b00:   bad = 1'b0;
      2'b01:   bad = lane[0];
      2'b10:   bad = (lane != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Merge the narrow store data into its byte lanes, leaving the other lanes intact
  function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] din,
                                              input logic [1:0] size, input logic [1:0] lane);
    logic [31:0] w;
    w = old;
    case (size)
      2'b00:   w[{lane, 3'b000} +: 8]     = din[7:0];
      2'b01:   w[{lane[1], 4'b0000} +: 16] = din[15:0];
      default: w = din;
    endcase
    return w;
  endfunction

  // Right-justify the selected byte/half and extend it; words pass through
  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] lane, input logic uns);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] sx;
    logic [31:0]        res;
    b  = word[{lane, 3'b000} +: 8];
    h  = word[{lane[1], 4'b0000} +: 16];
    res = word;
    case (size)
      2'b00: begin
        sx  = b;
        res = uns ? {24'd0, b} : sx;
      end
      2'b01: begin
        sx  = h;
        res = uns ? {16'd0, h} : sx;
      end
      default: res = word;
    endcase
    return res;
  endfunction

  // Access fields: live bus inputs on the accepting cycle, captured copies afterwards
  always_comb begin
    acc_wr   = wr_q;
    acc_adr  = adr_q;
    acc_din  = din_q;
    acc_size = size_q;
    acc_uns  = uns_q;
    if (state_q == ST_IDLE) begin
      acc_wr   = bus.WrEn;
      acc_adr  = bus.Adr[ADDR_W-1:0];
      acc_din  = bus.DataIn;
      acc_size = bus.Size;
      acc_uns  = bus.Unsigned;
    end
  end

  assign acc_idx  = acc_adr[ADDR_W-1:2];
  assign cur_word = mem_q[acc_idx];
  assign illegal  = is_illegal(acc_size, acc_adr[1:0]);
  assign accept   = (state_q == ST_IDLE) && ready_q && bus.Req;
  assign finish   = !Reset && ((accept && (WAIT_CYC == 0)) ||
                               ((state_q == ST_WAIT) && (cnt_q == 4'd0)));

  // Array write port: zero sweep during INIT, merged lanes on a legal store commit
  always_comb begin
    mem_we    = 1'b0;
    mem_widx  = acc_idx;
    mem_wdata = store_merge(cur_word, acc_din, acc_size, acc_adr[1:0]);
    if (state_q == ST_INIT) begin
      mem_we    = !Reset;
      mem_widx  = clr_ptr_q;
      mem_wdata = '0;
    end else if (finish && acc_wr && !illegal) begin
      mem_we = 1'b1;
    end
  end

  // Next-state logic for the control FSM, its registered outputs and captured fields
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    clr_ptr_d = clr_ptr_q;
    ready_d   = ready_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    dout_d    = dout_q;
    wr_d      = wr_q;
    adr_d     = adr_q;
    din_d     = din_q;
    size_d    = size_q;
    uns_d     = uns_q;

    case (state_q)
      ST_INIT: begin
        clr_ptr_d = clr_ptr_q + IDX_W'(1);
        if (clr_ptr_q == LAST_IDX) begin
          state_d   = ST_IDLE;
          ready_d   = 1'b1;
          clr_ptr_d = '0;
        end
      end
      ST_IDLE: begin
        ready_d = 1'b1;
        if (accept) begin
          wr_d    = bus.WrEn;
          adr_d   = bus.Adr[ADDR_W-1:0];
          din_d   = bus.DataIn;
          size_d  = bus.Size;
          uns_d   = bus.Unsigned;
          ready_d = 1'b0;
          if (WAIT_CYC == 0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
    endcase

    if (finish) begin
      done_d = 1'b1;
      err_d  = illegal;
      if (!acc_wr && !illegal) begin
        dout_d = load_extract(cur_word, acc_size, acc_adr[1:0], acc_uns);
      end
    end
  end

  // Control FSM registers; reset aborts any access in flight
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= CLEAR_ON_RESET ? ST_INIT : ST_IDLE;
      cnt_q     <= '0;
      clr_ptr_q <= '0;
      ready_q   <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      dout_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      clr_ptr_q <= clr_ptr_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      err_q     <= err_d;
      dout_q    <= dout_d;
    end
  end

  // Captured request fields carry no reset; they are only read after a capture
  always_ff @(posedge Clk) begin
    wr_q   <= wr_d;
    adr_q  <= adr_d;
    din_q  <= din_d;
    size_q <= size_d;
    uns_q  <= uns_d;
  end

  // Storage array write
  always_ff @(posedge Clk) begin
    if (mem_we) begin
      mem_q[mem_widx] <= mem_wdata;
    end
  end

  assign bus.Ready   = ready_q;
  assign bus.Done    = done_q;
  assign bus.Err     = err_q;
  assign bus.DataOut = dout_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: a default build (2 wait states, clear on reset) and a
// zero-wait build without clear, both compared against a byte-array model.
`timescale 1ns/1ps
module tb_data_mem_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0;
  logic rst1;

  data_mem_ctrl_if b0();
  data_mem_ctrl_if b1();

  data_mem_ctrl #(.ADDR_W(12), .WAIT_CYC(2), .CLEAR_ON_RESET(1'b1)) dut0 (
    .Clk(clk), .Reset(rst0), .bus(b0)
  );
  data_mem_ctrl #(.ADDR_W(12), .WAIT_CYC(0), .CLEAR_ON_RESET(1'b0)) dut1 (
    .Clk(clk), .Reset(rst1), .bus(b1)
  );

  int checks = 0;
  int passes = 0;

  // Reference model: byte-addressed memory image and held load result per build
  logic [7:0]  mm   [2][4096];
  logic [31:0] dexp [2];
  int          lat_exp [2] = '{3, 1};

  function automatic bit m_legal(input logic [31:0] a, input logic [1:0] sz);
    if (sz == 2'b11) return 1'b0;
    if (sz == 2'b01 && a[0]) return 1'b0;
    if (sz == 2'b10 && a[1:0] != 2'b00) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int m_bytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] m_load(input int d, input logic [31:0] a,
                                         input logic [1:0] sz, input bit uns);
    int n;
    int base;
    logic [31:0] v;
    n = m_bytes(sz);
    base = int'(a[11:0]) & ~(n - 1);
    v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = mm[d][base + i];
    if (!uns && n == 1 && v[7])  v[31:8]  = '1;
    if (!uns && n == 2 && v[15]) v[31:16] = '1;
    return v;
  endfunction

  task automatic m_apply(input int d, input bit wr, input logic [31:0] a, input logic [31:0] din,
                         input logic [1:0] sz, input bit uns,
                         output bit e_err, output logic [31:0] e_dout);
    int n;
    int base;
    e_err = !m_legal(a, sz);
    if (!e_err) begin
      if (wr) begin
        n = m_bytes(sz);
        base = int'(a[11:0]) & ~(n - 1);
        for (int i = 0; i < n; i++) mm[d][base + i] = din[8*i +: 8];
      end else begin
        dexp[d] = m_load(d, a, sz, uns);
      end
    end
    e_dout = dexp[d];
  endtask

  function automatic logic rdy(input int d);
    return (d == 0) ? b0.Ready : b1.Ready;
  endfunction

  function automatic logic dn(input int d);
    return (d == 0) ? b0.Done : b1.Done;
  endfunction

  task automatic drive(input int d, input bit req, input bit wr, input logic [31:0] a,
                       input logic [31:0] din, input logic [1:0] sz, input bit uns);
    if (d == 0) begin
      b0.Req = req; b0.WrEn = wr; b0.Adr = a; b0.DataIn = din; b0.Size = sz; b0.Unsigned = uns;
    end else begin
      b1.Req = req; b1.WrEn = wr; b1.Adr = a; b1.DataIn = din; b1.Size = sz; b1.Unsigned = uns;
    end
  endtask

  // One access: wait for Ready, present the request, scramble the inputs after
  // acceptance, optionally keep requesting junk while busy, and report what came back.
  task automatic op(input int d, input bit wr, input logic [31:0] a, input logic [31:0] din,
                    input logic [1:0] sz, input bit uns, input bit poke,
                    output int lat, output bit err, output bit rdy_fall, output logic [31:0] dout,
                    output bit e_err, output logic [31:0] e_dout);
    int n;
    lat = -1; err = 1'b0; rdy_fall = 1'b0; dout = 'x;
    n = 0;
    @(negedge clk);
    while (!rdy(d) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    m_apply(d, wr, a, din, sz, uns, e_err, e_dout);
    if (!rdy(d)) return;
    drive(d, 1'b1, wr, a, din, sz, uns);
    @(posedge clk);
    #1;
    drive(d, 1'b0, 1'($urandom), $urandom, $urandom, 2'($urandom), 1'($urandom));
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) rdy_fall = !rdy(d);
      if (dn(d)) begin
        lat  = k;
        err  = (d == 0) ? b0.Err : b1.Err;
        dout = (d == 0) ? b0.DataOut : b1.DataOut;
        break;
      end
      if (poke) drive(d, 1'b1, !wr, a ^ 32'h4, ~din, sz, !uns);
    end
    drive(d, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
  endtask

  task automatic test_reset();
    int n;
    rst0 = 1'b1; rst1 = 1'b1;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst0 = 1'b0; rst1 = 1'b0;
    checks++; if (b0.Ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", b0.Ready); else passes++;
    checks++; if (b0.Done !== 1'b0) $display("FAIL reset_done: got %b want 0", b0.Done); else passes++;
    checks++; if (b0.Err !== 1'b0) $display("FAIL reset_err: got %b want 0", b0.Err); else passes++;
    checks++; if (b0.DataOut !== 32'h0) $display("FAIL reset_dout: got %h want 0", b0.DataOut); else passes++;
    checks++; if (b1.DataOut !== 32'h0) $display("FAIL reset_dout_nc: got %h want 0", b1.DataOut); else passes++;
    n = 0;
    forever begin
      @(negedge clk);
      if (n == 1) begin
        checks++;
        if (b1.Ready !== 1'b1) $display("FAIL noclear_ready: got %b want 1", b1.Ready); else passes++;
      end
      if (b0.Ready === 1'b1 || n >= 3000) break;
      n++;
    end
    checks++; if (n != 1024) $display("FAIL init_cycles: got %0d want 1024", n); else passes++;
    for (int i = 0; i < 4096; i++) mm[0][i] = 8'h00;
    dexp[0] = '0; dexp[1] = '0;
  endtask

  task automatic test_word();
    int lat; bit err, rf, ee; logic [31:0] dout, ed;
    op(0, 1'b1, 32'h10, 32'h12345678, 2'b10, 1'b0, 1'b0, lat, err, rf, dout, ee, ed);
    checks++; if (lat != 3) $display("FAIL sw_latency: got %0d want 3", lat); else passes++;
    checks++; if (rf !== 1'b1) $display("FAIL sw_ready_fall: got %b want 1", rf); else passes++;
    op(0, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 1'b0, lat, err, rf, dout, ee, ed);
    checks++; if (lat != 3) $display("FAIL lw_latency: got %0d want 3", lat); else passes++;
    checks++; if (dout !== 32'h12345678 || err !== 1'b0)
      $display("FAIL lw_data: got %h err %b want 12345678 err 0", dout, err); else passes++;
    @(negedge clk);
    checks++; if (b0.Ready !== 1'b1 || b0.DataOut !== 32'h12345678)
      $display("FAIL lw_after: got ready %b dout %h want 1 12345678", b0.Ready, b0.DataOut); else passes++;
  endtask

  task automatic test_byte_lanes();
    int lat; bit err, rf, ee; logic [31:0] dout, ed;
    op(0, 1'b1, 32'h21, 32'hAAAA_AA80, 2'b00, 1'b0, 1'b0, lat, err, rf, dout, ee, ed);
    op(0, 1'b1, 32'h23, 32'h5555_557F, 2'b00, 1'b0, 1'b0, lat, err, rf, dout, ee, ed);
    op(0, 1'b0, 32'h20, 32'h0, 2'b10, 1'b0, 1'b0, lat, err, rf, dout, ee, ed);
    checks++; if (dout !== 32'h7F008000) $display("FAIL byte_word: got %h want 7f008000", dout); else passes++;
    op(0, 1'b0, 32'h21, 32'h0, 2'b00, 1'b0, 1'b0, lat, err, rf, dout, ee, ed);
    checks++; if (dout !== 32'hFFFFFF80) $display("FAIL lb: got %h want ffffff80", dout); else passes++;
    op(0, 1'b0, 32'h21, 32'h0, 2'b00, 1'b1, 1'b0, lat, err, rf, dout, ee, ed);
    checks++; if (dout !== 32'h00000080) $display("FAIL lbu: got %h want 00000080", dout); else passes++;
  endtask

  task automatic test_half();
    int lat; bit err, rf, ee; logic [31:0] dout, ed;
    op(0, 1'b1, 32'h32, 32'h1234_BEEF, 2'b01, 1'b0, 1'b0, lat, err, rf, dout, ee, ed);
    op(0, 1'b0, 32'h32, 32'h0, 2'b01, 1'b0, 1'b0, lat, err, rf, dout, ee, ed);
    checks++; if (dout !== 32'hFFFFBEEF) $display("FAIL lh: got %h want ffffbeef", dout); else passes++;
    op(0, 1'b0, 32'h32, 32'h0, 2'b01, 1'b1, 1'b0, lat, err, rf, dout, ee, ed);
    checks++; if (dout !== 32'h0000BEEF) $display("FAIL lhu: got %h want 0000beef", dout); else passes++;
    op(0, 1'b0, 32'h30, 32'h0, 2'b10, 1'b0, 1'b0, lat, err, rf, dout, ee, ed);
    checks++; if (dout !== 32'hBEEF0000) $display("FAIL half_word: got %h want beef0000", dout); else passes++;
  endtask

  task automatic test_errors();
    int lat; bit err, rf, ee; logic [31:0] dout, ed;
    op(0, 1'b1, 32'h40, 32'hA5A5A5A5, 2'b10, 1'b0, 1'b0, lat, err, rf, dout, ee, ed);
    op(0, 1'b0, 32'h40, 32'h0, 2'b10, 1'b0, 1'b0, lat, err, rf, dout, ee, ed);
    op(0, 1'b0, 32'h41, 32'h0, 2'b10, 1'b0, 1'b0, lat, err, rf, dout, ee, ed);
    checks++; if (err !== 1'b1 || lat != 3 || dout !== 32'hA5A5A5A5)
      $display("FAIL err_lw: got err %b lat %0d dout %h want 1 3 a5a5a5a5", err, lat, dout); else passes++;
    op(0, 1'b1, 32'h43, 32'h0000_1111, 2'b01, 1'b0, 1'b0, lat, err, rf, dout, ee, ed);
    checks++; if (err !== 1'b1 || dout !== 32'hA5A5A5A5)
      $display("FAIL err_sh: got err %b dout %h want 1 a5a5a5a5", err, dout); else passes++;
    op(0, 1'b1, 32'h40, 32'h0000_2222, 2'b11, 1'b0, 1'b0, lat, err, rf, dout, ee, ed);
    checks++; if (err !== 1'b1) $display("FAIL err_size11: got err %b want 1", err); else passes++;
    op(0, 1'b0, 32'h40, 32'h0, 2'b10, 1'b0, 1'b0, lat, err, rf, dout, ee, ed);
    checks++; if (dout !== 32'hA5A5A5A5 || err !== 1'b0)
      $display("FAIL err_untouched: got %h err %b want a5a5a5a5 0", dout, err); else passes++;
  endtask

  task automatic test_req_in_wait();
    int lat; bit err, rf, ee; logic [31:0] dout, ed;
    int extra;
    op(0, 1'b1, 32'h44, 32'h0BADF00D, 2'b10, 1'b0, 1'b1, lat, err, rf, dout, ee, ed);
    checks++; if (lat != 3) $display("FAIL poke_latency: got %0d want 3", lat); else passes++;
    extra = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (b0.Done === 1'b1) extra++;
    end
    checks++; if (extra != 0) $display("FAIL poke_extra_done: got %0d want 0", extra); else passes++;
    op(0, 1'b0, 32'h44, 32'h0, 2'b10, 1'b0, 1'b0, lat, err, rf, dout, ee, ed);
    checks++; if (dout !== 32'h0BADF00D) $display("FAIL poke_data: got %h want 0badf00d", dout); else passes++;
    op(0, 1'b0, 32'h40, 32'h0, 2'b10, 1'b0, 1'b0, lat, err, rf, dout, ee, ed);
    checks++; if (dout !== 32'hA5A5A5A5) $display("FAIL poke_neighbour: got %h want a5a5a5a5", dout); else passes++;
  endtask

  task automatic test_random();
    int lat; bit err, rf, ee; logic [31:0] dout, ed;
    logic [31:0] a, din;
    logic [1:0] sz;
    bit wr, uns;
    for (int i = 0; i < 150; i++) begin
      a   = ($urandom & 32'hFFFF_F000) | (32'h200 + 32'($urandom_range(0, 63)));
      din = $urandom;
      sz  = 2'($urandom_range(0, 3));
      wr  = 1'($urandom);
      uns = 1'($urandom);
      op(0, wr, a, din, sz, uns, 1'($urandom), lat, err, rf, dout, ee, ed);
      checks++; if (lat != lat_exp[0]) $display("FAIL rnd_lat[%0d]: got %0d want %0d", i, lat, lat_exp[0]); else passes++;
      checks++; if (err !== ee) $display("FAIL rnd_err[%0d]: got %b want %b", i, err, ee); else passes++;
      checks++; if (dout !== ed) $display("FAIL rnd_dout[%0d]: got %h want %h", i, dout, ed); else passes++;
    end
  endtask

  task automatic test_back_to_back();
    int t[$];
    int n;
    bit ee; logic [31:0] ed;
    n = 0;
    @(negedge clk);
    while (!b0.Ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    drive(0, 1'b1, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0);
    for (int k = 0; k < 40 && t.size() < 2; k++) begin
      @(negedge clk);
      if (b0.Done === 1'b1) t.push_back(k);
    end
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
    m_apply(0, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, ee, ed);
    checks++; if (t.size() != 2 || (t[1] - t[0]) != 4)
      $display("FAIL b2b_interval: got %0d dones gap %0d want 2 dones gap 4", t.size(),
               (t.size() == 2) ? t[1] - t[0] : -1); else passes++;
    checks++; if (b0.DataOut !== ed) $display("FAIL b2b_data: got %h want %h", b0.DataOut, ed); else passes++;
  endtask

  task automatic test_reset_clear();
    int lat, n; bit err, rf, ee; logic [31:0] dout, ed;
    op(0, 1'b1, 32'h3FC, 32'hDEADBEEF, 2'b10, 1'b0, 1'b0, lat, err, rf, dout, ee, ed);
    @(negedge clk);
    rst0 = 1'b1;
    @(posedge clk);
    #1;
    rst0 = 1'b0;
    for (int i = 0; i < 4096; i++) mm[0][i] = 8'h00;
    dexp[0] = '0;
    n = 0;
    forever begin
      @(negedge clk);
      if (b0.Ready === 1'b1 || n >= 3000) break;
      n++;
    end
    checks++; if (n != 1024) $display("FAIL reclear_cycles: got %0d want 1024", n); else passes++;
    op(0, 1'b0, 32'h3FC, 32'h0, 2'b10, 1'b0, 1'b0, lat, err, rf, dout, ee, ed);
    checks++; if (dout !== 32'h0 || lat != 3) $display("FAIL reclear_data: got %h lat %0d want 0 3", dout, lat); else passes++;
  endtask

  task automatic test_midop_reset();
    int lat, n, dones; bit err, rf, ee; logic [31:0] dout, ed;
    n = 0;
    @(negedge clk);
    while (!b0.Ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    drive(0, 1'b1, 1'b1, 32'h50, 32'h77777777, 2'b10, 1'b0);
    @(posedge clk);
    #1;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
    repeat (2) @(negedge clk);
    rst0 = 1'b1;
    @(posedge clk);
    #1;
    rst0 = 1'b0;
    dexp[0] = '0;
    dones = 0;
    n = 0;
    forever begin
      @(negedge clk);
      if (b0.Done === 1'b1) dones++;
      if (b0.Ready === 1'b1 || n >= 3000) break;
      n++;
    end
    checks++; if (dones != 0 || n != 1024)
      $display("FAIL midop_abort: got dones %0d init %0d want 0 1024", dones, n); else passes++;
    op(0, 1'b0, 32'h50, 32'h0, 2'b10, 1'b0, 1'b0, lat, err, rf, dout, ee, ed);
    checks++; if (dout !== 32'h0) $display("FAIL midop_data: got %h want 0", dout); else passes++;
  endtask

  task automatic test_nowait();
    int lat; bit err, rf, ee; logic [31:0] dout, ed;
    op(1, 1'b1, 32'h100, 32'hCAFEF00D, 2'b10, 1'b0, 1'b0, lat, err, rf, dout, ee, ed);
    checks++; if (lat != 1 || rf !== 1'b1) $display("FAIL nw_latency: got %0d fall %b want 1 1", lat, rf); else passes++;
    op(1, 1'b1, 32'h101, 32'h00000011, 2'b00, 1'b0, 1'b0, lat, err, rf, dout, ee, ed);
    @(negedge clk);
    rst1 = 1'b1;
    @(posedge clk);
    #1;
    rst1 = 1'b0;
    dexp[1] = '0;
    checks++; if (b1.DataOut !== 32'h0) $display("FAIL nw_reset_dout: got %h want 0", b1.DataOut); else passes++;
    op(1, 1'b0, 32'hFFFFF100, 32'h0, 2'b10, 1'b0, 1'b0, lat, err, rf, dout, ee, ed);
    checks++; if (dout !== 32'hCAFE110D || lat != 1)
      $display("FAIL nw_persist: got %h lat %0d want cafe110d 1", dout, lat); else passes++;
    op(1, 1'b0, 32'h102, 32'h0, 2'b01, 1'b1, 1'b0, lat, err, rf, dout, ee, ed);
    checks++; if (dout !== 32'h0000CAFE) $display("FAIL nw_lhu: got %h want 0000cafe", dout); else passes++;
    op(1, 1'b0, 32'h100, 32'h0, 2'b01, 1'b0, 1'b0, lat, err, rf, dout, ee, ed);
    checks++; if (dout !== ed || dout !== 32'h0000110D) $display("FAIL nw_lh: got %h want 0000110d", dout); else passes++;
    op(1, 1'b0, 32'h102, 32'h0, 2'b10, 1'b0, 1'b0, lat, err, rf, dout, ee, ed);
    checks++; if (err !== 1'b1 || dout !== 32'h0000110D)
      $display("FAIL nw_err: got err %b dout %h want 1 0000110d", err, dout); else passes++;
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte_lanes();
    test_half();
    test_errors();
    test_req_in_wait();
    test_random();
    test_back_to_back();
    test_reset_clear();
    test_midop_reset();
    test_nowait();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
